// File: rtl/ring_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : ring_scan_display
// Brief    : 4-digit multiplexed 7-segment driver strobed by a one-hot ring
//            counter phase, with tear-free frame-boundary loading and phase
//            legality checking. Define RING_SCAN_HEX_EN to show codes 10-15
//            as A,b,C,d,E,F instead of blanking them.
// Revision : 1.0  initial release
// ============================================================================
module ring_scan_display #(
    parameter int BLANK_CYC  = 1,
    parameter int ERR_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  phase,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_tick,
    output logic        err
);

    localparam int              c_BW     = (BLANK_CYC < 1) ? 1 : $clog2(BLANK_CYC + 1);
    localparam logic [c_BW-1:0] c_BLANK  = c_BW'(BLANK_CYC);
    localparam logic [c_BW-1:0] c_ONE    = c_BW'(1);
    localparam logic [3:0]      c_THRESH = 4'(ERR_THRESH);

    logic [3:0]      r_phase_q;
    logic            r_q_legal;
    logic [c_BW-1:0] r_blank;
    logic [3:0]      r_err_cnt;
    logic            r_err;
    logic [15:0]     r_display;
    logic [15:0]     r_pending;
    logic            r_pend_vld;
    logic            r_load_ready;
    logic            r_frame_tick;
    logic [6:0]      r_seg_n;
    logic [3:0]      r_an_n;

    logic            w_onehot;
    logic [3:0]      w_step;
    logic            w_legal;
    logic            w_wrap;
    logic            w_accept;
    logic [3:0]      w_cnt_inc;
    logic [3:0]      w_digit;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
`ifdef RING_SCAN_HEX_EN
            4'd10:   s = 7'h08;
            4'd11:   s = 7'h03;
            4'd12:   s = 7'h46;
            4'd13:   s = 7'h21;
            4'd14:   s = 7'h06;
            default: s = 7'h0E;
`else
            default: s = 7'h7F;
`endif
        endcase
        return s;
    endfunction

    // Legal means one-hot and either holding or advancing one step of the ring.
    assign w_onehot  = (phase != 4'h0) && ((phase & (phase - 4'd1)) == 4'h0);
    assign w_step    = {r_phase_q[0], r_phase_q[3:1]};
    assign w_legal   = w_onehot && ((phase == r_phase_q) || (phase == w_step));
    assign w_wrap    = w_legal && (r_phase_q == 4'b0010) && (phase == 4'b0001);
    assign w_accept  = load_valid && r_load_ready;
    assign w_cnt_inc = (r_err_cnt == 4'hF) ? 4'hF : (r_err_cnt + 4'd1);

    always_comb begin
        w_digit = 4'hF;
        case (r_phase_q)
            4'b0001: w_digit = r_display[3:0];
            4'b0010: w_digit = r_display[7:4];
            4'b0100: w_digit = r_display[11:8];
            4'b1000: w_digit = r_display[15:12];
            default: w_digit = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_q    <= 4'b0001;
            r_q_legal    <= 1'b1;
            r_blank      <= '0;
            r_err_cnt    <= 4'h0;
            r_err        <= 1'b0;
            r_display    <= 16'h0000;
            r_pending    <= 16'h0000;
            r_pend_vld   <= 1'b0;
            r_load_ready <= 1'b1;
            r_frame_tick <= 1'b0;
            r_seg_n      <= 7'h7F;
            r_an_n       <= 4'hF;
        end else begin
            r_phase_q <= phase;
            r_q_legal <= w_legal;

            if (phase != r_phase_q) begin
                r_blank <= c_BLANK;
            end else if (r_blank != '0) begin
                r_blank <= r_blank - c_ONE;
            end

            if (w_legal) begin
                r_err_cnt <= 4'h0;
            end else begin
                r_err_cnt <= w_cnt_inc;
                if (w_cnt_inc >= c_THRESH) begin
                    r_err <= 1'b1;
                end
            end

            r_frame_tick <= w_wrap;
            r_an_n       <= (r_q_legal && (r_blank == '0)) ? ~r_phase_q : 4'hF;
            r_seg_n      <= r_q_legal ? seg_decode(w_digit) : 7'h7F;

            // Commit uses the pending flag from before this edge, so a word
            // accepted on the wrap edge itself waits a full frame.
            if (w_wrap && r_pend_vld) begin
                r_display  <= r_pending;
                r_pend_vld <= 1'b0;
            end
            if (w_accept) begin
                r_pending  <= load_data;
                r_pend_vld <= 1'b1;
            end
            r_load_ready <= !w_accept && !r_pend_vld;
        end
    end

    assign load_ready = r_load_ready;
    assign seg_n      = r_seg_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_scan_display
// Brief    : Self-checking bench: two ring_scan_display instances (BLANK_CYC 0
//            and 2) against a behavioural model, plus literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_ring_scan_display;

    localparam int BLANK_A = 0;
    localparam int BLANK_B = 2;
    localparam int THRESH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  phase;
    logic        load_valid;
    logic [15:0] load_data;

    logic        lr0, lr2, ft0, ft2, err0, err2;
    logic [6:0]  seg0, seg2;
    logic [3:0]  an0, an2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ring_scan_display #(.BLANK_CYC(BLANK_A), .ERR_THRESH(THRESH)) u_dut_b0 (
        .clk(clk), .rst_n(rst_n), .phase(phase), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr0), .seg_n(seg0), .an_n(an0),
        .frame_tick(ft0), .err(err0)
    );

    ring_scan_display #(.BLANK_CYC(BLANK_B), .ERR_THRESH(THRESH)) u_dut_b2 (
        .clk(clk), .rst_n(rst_n), .phase(phase), .load_valid(load_valid),
        .load_data(load_data), .load_ready(lr2), .seg_n(seg2), .an_n(an2),
        .frame_tick(ft2), .err(err2)
    );

`ifdef RING_SCAN_HEX_EN
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_F = 7'h0E;
`else
    localparam logic [6:0] SEG_A = 7'h7F;
    localparam logic [6:0] SEG_F = 7'h7F;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
`ifdef RING_SCAN_HEX_EN
            4'd10: return 7'h08; 4'd11: return 7'h03; 4'd12: return 7'h46;
            4'd13: return 7'h21; 4'd14: return 7'h06; default: return 7'h0E;
`else
            default: return 7'h7F;
`endif
        endcase
    endfunction

    // Bit index of a one-hot value, -1 otherwise.
    function automatic int idx_of(input logic [3:0] v);
        int n = 0;
        int k = -1;
        for (int b = 0; b < 4; b++) begin
            if (v[b]) begin
                n++;
                k = b;
            end
        end
        return (n == 1) ? k : -1;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: digit contents, pending word, phase history and age
    logic [3:0] m_q;
    bit         m_q_ok;
    int         m_age;
    int         m_cnt;
    bit         m_err;
    logic [3:0] m_disp [4];
    logic [3:0] m_pend [4];
    bit         m_pend_vld;
    bit         m_lr;
    bit         m_ft;
    bit         m_commit_prev;
    logic [6:0] m_seg;
    logic [3:0] m_an [2];

    task automatic model_step();
        int  qi, pi;
        bit  ok, wrap, acc, commit;
        int  blank [2];
        blank[0] = BLANK_A;
        blank[1] = BLANK_B;
        if (!rst_n) begin
            m_q = 4'b0001; m_q_ok = 1'b1; m_age = 1000; m_cnt = 0; m_err = 1'b0;
            for (int d = 0; d < 4; d++) begin
                m_disp[d] = 4'h0;
                m_pend[d] = 4'h0;
            end
            m_pend_vld = 1'b0; m_lr = 1'b1; m_ft = 1'b0; m_commit_prev = 1'b0;
            m_seg = 7'h7F; m_an[0] = 4'hF; m_an[1] = 4'hF;
        end else begin
            qi = idx_of(m_q);
            pi = idx_of(phase);
            // Display outputs reflect the phase sample from the previous edge.
            for (int i = 0; i < 2; i++)
                m_an[i] = (m_q_ok && m_age >= blank[i]) ? ~m_q : 4'hF;
            if (m_q_ok) m_seg = seg_of(m_disp[qi]);
            else        m_seg = 7'h7F;
            ok     = (pi >= 0) && (qi >= 0) && (pi == qi || pi == (qi + 3) % 4);
            wrap   = ok && (qi == 1) && (pi == 0);
            acc    = load_valid && m_lr;
            commit = wrap && m_pend_vld;
            if (acc)                m_lr = 1'b0;
            else if (m_commit_prev) m_lr = 1'b1;
            m_commit_prev = commit;
            if (commit) begin
                m_disp     = m_pend;
                m_pend_vld = 1'b0;
            end
            if (acc) begin
                for (int d = 0; d < 4; d++) m_pend[d] = load_data[4*d +: 4];
                m_pend_vld = 1'b1;
            end
            m_ft  = wrap;
            m_cnt = ok ? 0 : ((m_cnt < 15) ? m_cnt + 1 : 15);
            if (m_cnt >= THRESH) m_err = 1'b1;
            m_age = (phase != m_q) ? 0 : ((m_age < 1000) ? m_age + 1 : 1000);
            m_q    = phase;
            m_q_ok = ok;
        end
    endtask

    // Inputs change at negedge+1, so at each negedge they still hold the
    // values the preceding posedge sampled.
    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("an_n b0",      {12'h0, an0},  {12'h0, m_an[0]});
            chk("an_n b2",      {12'h0, an2},  {12'h0, m_an[1]});
            chk("seg_n b0",     {9'h0, seg0},  {9'h0, m_seg});
            chk("seg_n b2",     {9'h0, seg2},  {9'h0, m_seg});
            chk("frame_tick",   {14'h0, ft0, ft2},  {14'h0, m_ft, m_ft});
            chk("err",          {14'h0, err0, err2}, {14'h0, m_err, m_err});
            chk("load_ready",   {14'h0, lr0, lr2},  {14'h0, m_lr, m_lr});
        end
    end

    task automatic cyc(input logic [3:0] p, input logic lv, input logic [15:0] d);
        phase      = p;
        load_valid = lv;
        load_data  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic rot_frame();
        cyc(4'b1000, 1'b0, 16'h0);
        cyc(4'b0100, 1'b0, 16'h0);
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b0, 16'h0);
    endtask

    initial begin
        logic [3:0] cur;
        int         run;
        int         ix;
        rst_n = 1'b1; phase = 4'b0001; load_valid = 1'b0; load_data = 16'h0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("reset an_n",  {12'h0, an0}, 16'h000F);
        chk("reset seg_n", {9'h0, seg0}, 16'h007F);
        chk("reset ready", {15'h0, lr0}, 16'h0001);
        rst_n = 1'b1;

        // Plain rotation, no load: anodes follow ~phase two edges later
        cyc(4'b0001, 1'b0, 16'h0);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("rot an d0",  {12'h0, an0}, 16'h000E);
        chk("rot seg d0", {9'h0, seg0}, 16'h0040);
        cyc(4'b0100, 1'b0, 16'h0);
        chk("rot an d3",  {12'h0, an0}, 16'h0007);
        cyc(4'b0010, 1'b0, 16'h0);
        chk("rot an d2",  {12'h0, an0}, 16'h000B);
        cyc(4'b0001, 1'b0, 16'h0);
        chk("rot an d1",  {12'h0, an0}, 16'h000D);
        chk("rot tick",   {15'h0, ft0}, 16'h0001);

        // Mid-frame load of 1234
        cyc(4'b1000, 1'b1, 16'h1234);
        chk("load ready drop", {15'h0, lr0}, 16'h0000);
        cyc(4'b0100, 1'b0, 16'h0);
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b0, 16'h0);
        chk("commit tick",       {15'h0, ft0}, 16'h0001);
        chk("ready in tick",     {15'h0, lr0}, 16'h0000);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("ready after tick",  {15'h0, lr0}, 16'h0001);
        chk("1234 digit0",       {9'h0, seg0}, 16'h0019);
        cyc(4'b0100, 1'b0, 16'h0);
        chk("1234 digit3",       {9'h0, seg0}, 16'h0079);
        cyc(4'b0010, 1'b0, 16'h0);
        chk("1234 digit2",       {9'h0, seg0}, 16'h0024);
        cyc(4'b0001, 1'b0, 16'h0);
        chk("1234 digit1",       {9'h0, seg0}, 16'h0030);

        // Non-decimal codes
        cyc(4'b1000, 1'b1, 16'hFA00);
        cyc(4'b0100, 1'b0, 16'h0);
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b0, 16'h0);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("FA00 digit0", {9'h0, seg0}, 16'h0040);
        cyc(4'b0100, 1'b0, 16'h0);
        chk("FA00 digit3", {9'h0, seg0}, {9'h0, SEG_F});
        cyc(4'b0010, 1'b0, 16'h0);
        chk("FA00 digit2", {9'h0, seg0}, {9'h0, SEG_A});

        // Blanking after each change on the BLANK_CYC=2 instance
        for (int i = 0; i < 4; i++) cyc(4'b0001, 1'b0, 16'h0);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("blank held", {12'h0, an2}, 16'h000E);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("blank 1",    {12'h0, an2}, 16'h000F);
        chk("noblank 1",  {12'h0, an0}, 16'h0007);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("blank 2",    {12'h0, an2}, 16'h000F);
        cyc(4'b1000, 1'b0, 16'h0);
        chk("blank done", {12'h0, an2}, 16'h0007);

        // Two consecutive multi-hot samples set sticky err
        cyc(4'b0100, 1'b0, 16'h0);
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b0, 16'h0);
        cyc(4'b0011, 1'b0, 16'h0);
        chk("err below thresh", {15'h0, err0}, 16'h0000);
        cyc(4'b0011, 1'b0, 16'h0);
        chk("err at thresh",    {15'h0, err0}, 16'h0001);
        chk("illegal an_n off", {12'h0, an0},  16'h000F);
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b0, 16'h0);
        cyc(4'b1000, 1'b0, 16'h0);
        cyc(4'b0100, 1'b0, 16'h0);
        chk("err sticky",       {15'h0, err0}, 16'h0001);
        chk("an_n resumes",     {12'h0, an0},  16'h0007);

        // Reset while a word is pending: word dropped, display back to 0
        cyc(4'b0010, 1'b0, 16'h0);
        cyc(4'b0001, 1'b1, 16'h5678);
        cyc(4'b1000, 1'b0, 16'h0);
        rst_n = 1'b0;
        #1;
        chk("async rst an_n",  {12'h0, an0}, 16'h000F);
        chk("async rst seg_n", {9'h0, seg0}, 16'h007F);
        chk("async rst ready", {15'h0, lr0}, 16'h0001);
        chk("async rst err",   {15'h0, err0}, 16'h0000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b0001, 1'b0, 16'h0);
        rot_frame();
        cyc(4'b1000, 1'b0, 16'h0);
        chk("post-rst digit0", {9'h0, seg0}, 16'h0040);
        cyc(4'b0100, 1'b0, 16'h0);
        chk("post-rst digit3", {9'h0, seg0}, 16'h0040);

        // Randomized traffic: mostly legal rotation with variable holds,
        // sparse glitches, random loads and periodic resets
        cur = 4'b0100;
        run = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 600 == 599) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
                cur = 4'b0001;
                run = 2;
            end
            if ($urandom_range(0, 99) < 1) begin
                cur = 4'($urandom_range(0, 15));
            end else if (run == 0) begin
                ix  = idx_of(cur);
                cur = (ix < 0) ? 4'b0001 : 4'(1 << ((ix + 3) % 4));
                run = $urandom_range(0, 4);
            end else begin
                run--;
            end
            cyc(cur, ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
